// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: divider FSM states and default operand width.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_t;

   localparam int DIV_WIDTH_DEF = 4;

endpackage

// File: rtl/addsub_cell.sv
// 1-bit full adder with a mode input; mode=1 inverts b so a carry-in of 1 gives a-b.
module addsub_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic mode,
   output logic s,
   output logic cout
);

   logic bx;

   assign bx   = b ^ mode;
   assign s    = a ^ bx ^ cin;
   assign cout = (a & bx) | (cin & (a ^ bx));

endmodule

// File: rtl/div_trial_sub.sv
// Combinational WIDTH+1-bit trial subtractor d = a - {0,b}; d[WIDTH]=1 means negative.
module div_trial_sub #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH:0]   d
);

   logic [WIDTH:0]   bx;
   logic [WIDTH+1:0] c;
   logic             cout_unused;

   assign bx          = {1'b0, b};
   assign c[0]        = 1'b1;
   assign cout_unused = c[WIDTH+1];

   for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
      addsub_cell u_cell (
         .a    (a[i]),
         .b    (bx[i]),
         .cin  (c[i]),
         .mode (1'b1),
         .s    (d[i]),
         .cout (c[i+1])
      );
   end

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with divide-by-zero flag.
module div_seq
   import arith_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] R,
   output logic             DIVZ
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   div_state_t       st, st_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, dvd, yr, q_r, r_r;
   logic             divz_r;
   logic [WIDTH:0]   shf, diff;
   logic             qbit;
   logic [WIDTH-1:0] rem_nx, quo_nx;

   // dvd doubles as the quotient: dividend bits shift out the top, quotient bits in the bottom
   assign shf    = {rem, dvd[WIDTH-1]};
   assign qbit   = ~diff[WIDTH];
   assign rem_nx = qbit ? diff[WIDTH-1:0] : shf[WIDTH-1:0];
   assign quo_nx = {dvd[WIDTH-2:0], qbit};

   div_trial_sub #(.WIDTH(WIDTH)) u_sub (
      .a (shf),
      .b (yr),
      .d (diff)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         st     <= IDLE;
         cnt    <= '0;
         rem    <= '0;
         dvd    <= '0;
         yr     <= '0;
         q_r    <= '0;
         r_r    <= '0;
         divz_r <= 1'b0;
      end else begin
         st <= st_nx;
         case (st)
            IDLE: if (START) begin
               dvd    <= X;
               yr     <= Y;
               rem    <= '0;
               cnt    <= '0;
               divz_r <= 1'b0;
               if (Y == '0) begin
                  q_r    <= '1;
                  r_r    <= X;
                  divz_r <= 1'b1;
               end
            end
            RUN: begin
               rem <= rem_nx;
               dvd <= quo_nx;
               if (cnt == LAST) begin
                  q_r <= quo_nx;
                  r_r <= rem_nx;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      st_nx = st;
      BUSY  = 1'b0;
      DONE  = 1'b0;
      case (st)
         IDLE: if (START) st_nx = (Y == '0) ? FIN : RUN;
         RUN: begin
            BUSY = 1'b1;
            if (cnt == LAST) st_nx = FIN;
         end
         FIN: begin
            BUSY  = 1'b1;
            DONE  = 1'b1;
            st_nx = IDLE;
         end
         default: st_nx = IDLE;
      endcase
   end

   assign Q    = q_r;
   assign R    = r_r;
   assign DIVZ = divz_r;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed cases, mid-run reset, exhaustive 4-bit sweep, random ops vs arithmetic model.
module tb_div_seq;

   localparam int W = 4;

   logic         CLK   = 1'b0;
   logic         RST   = 1'b1;
   logic         START = 1'b0;
   logic [W-1:0] X     = '0;
   logic [W-1:0] Y     = '0;
   logic         BUSY, DONE, DIVZ;
   logic [W-1:0] Q, R;

   int n_cmp = 0;
   int n_bad = 0;

   div_seq #(.WIDTH(W)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .X     (X),
      .Y     (Y),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .Q     (Q),
      .R     (R),
      .DIVZ  (DIVZ)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_q"},    32'(Q),    0);
      chk({tag, "_r"},    32'(R),    0);
      chk({tag, "_done"}, 32'(DONE), 0);
      chk({tag, "_busy"}, 32'(BUSY), 0);
      chk({tag, "_divz"}, 32'(DIVZ), 0);
   endtask

   // Issue one division; latency counts sample points (negedges) after the START edge until DONE.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
      int           n, exp_lat;
      logic [W-1:0] eq, er;
      bit           seen;
      if (y == 0) begin
         eq = '1; er = x; exp_lat = 1;
      end else begin
         eq = x / y; er = x % y; exp_lat = W + 1;
      end
      @(negedge CLK);
      START = 1'b1; X = x; Y = y;
      n = 0; seen = 0;
      while (!seen && n < 4 * W) begin
         @(negedge CLK);
         n++;
         seen = DONE;
         if (hold) begin
            X = W'($urandom); Y = W'($urandom);
         end else begin
            START = 1'b0;
         end
      end
      chk("done_seen", 32'(seen), 1);
      chk("latency",   32'(n),    32'(exp_lat));
      chk("q",    32'(Q),    32'(eq));
      chk("r",    32'(R),    32'(er));
      chk("divz", 32'(DIVZ), 32'(y == 0));
      if (y != 0) begin
         chk("ident",  32'(Q) * 32'(y) + 32'(R), 32'(x));
         chk("r_lt_y", 32'(R < y), 1);
      end
      @(negedge CLK);
      chk("done_pulse", 32'(DONE), 0);
      chk("idle_after", 32'(BUSY), 0);
      START = 1'b0;
   endtask

   task automatic hold_check();
      logic [W-1:0] q0, r0;
      logic         d0;
      q0 = Q; r0 = R; d0 = DIVZ;
      repeat (3) begin
         @(negedge CLK);
         X = W'($urandom); Y = W'($urandom);
      end
      chk("hold_q",    32'(Q),    32'(q0));
      chk("hold_r",    32'(R),    32'(r0));
      chk("hold_divz", 32'(DIVZ), 32'(d0));
   endtask

   initial begin
      int dones;
      repeat (2) @(negedge CLK);
      chk_zero("reset");
      RST = 1'b0;

      run_op(4'd13, 4'd3, 1'b0);
      run_op(4'd15, 4'd1, 1'b0);
      run_op(4'd3,  4'd9, 1'b0);
      run_op(4'd7,  4'd0, 1'b0);
      run_op(4'd8,  4'd2, 1'b0);
      hold_check();

      // START held high with changing operands through the whole run
      run_op(4'd9, 4'd2, 1'b1);

      // Reset two cycles into a run, with START also high to test priority
      @(negedge CLK);
      START = 1'b1; X = 4'd14; Y = 4'd3;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1; START = 1'b1;
      @(negedge CLK);
      RST = 1'b0; START = 1'b0;
      chk_zero("midrst");
      dones = 0;
      repeat (2 * W) begin
         @(negedge CLK);
         if (DONE) dones++;
      end
      chk("midrst_nodone", 32'(dones), 0);
      run_op(4'd14, 4'd3, 1'b0);

      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            run_op(W'(x), W'(y), 1'b0);

      repeat (30) run_op(W'($urandom), W'($urandom), 1'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand/result bit width (legal range 2..16).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port START, input, 1, request to begin a division; sampled on a rising CLK edge.
REQ-005 SHALL have port X, input, WIDTH, the unsigned dividend; captured with START.
REQ-006 SHALL have port Y, input, WIDTH, the unsigned divisor; captured with START.
REQ-007 SHALL have port BUSY, output, 1, high while a division is in progress.
REQ-008 SHALL have port DONE, output, 1, a one-cycle pulse marking Q/R/DIVZ valid.
REQ-009 SHALL have port Q, output, WIDTH, the quotient.
REQ-010 SHALL have port R, output, WIDTH, the remainder.
REQ-011 SHALL have port DIVZ, output, 1, divide-by-zero flag for the last operation.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, FIN.
REQ-013 SHALL, in IDLE with START=1, latch X and Y, clear the iteration counter and clear DIVZ.
REQ-014 SHALL, after that latch, go to RUN when Y!=0, or go to FIN with Q=all-ones, R=X, DIVZ=1 when Y==0.
REQ-015 SHALL perform restoring division in RUN, one quotient bit per cycle, MSB first.
REQ-016 SHALL, per RUN step, shift {partial remainder, dividend} left by one and form a WIDTH+1-bit trial difference of partial remainder minus Y.
REQ-017 SHALL, when the trial difference is non-negative (bit WIDTH = 0), keep it as the remainder and set the new quotient bit to 1.
REQ-018 SHALL, when the trial difference is negative, restore the remainder and set the new quotient bit to 0.
REQ-019 SHALL leave RUN for FIN after exactly WIDTH steps, counting the counter 0..WIDTH-1 with no wrap-around.
REQ-020 SHALL assert DONE for exactly one cycle in FIN, then return to IDLE.
REQ-021 SHALL give a latency of WIDTH+1 cycles from the START sampling edge to DONE high for Y!=0, and 1 cycle for Y==0.
REQ-022 SHALL drive BUSY=1 in RUN and FIN, and 0 in IDLE.
REQ-023 SHALL ignore START while BUSY=1, including during the FIN cycle, with no effect on the operation in flight.
REQ-024 SHALL hold Q, R and DIVZ stable from DONE until the next accepted START.
REQ-025 SHALL leave X and Y free to change after the START edge without affecting the result.
REQ-026 SHALL produce results satisfying X = Q*Y + R with R < Y for every Y!=0.

Reset
REQ-027 SHALL, on RST=1 at a clock edge, force state=IDLE, Q=0, R=0, DONE=0, BUSY=0, DIVZ=0 and counter=0.
REQ-028 SHALL give RST priority over START.
REQ-029 SHALL, on reset mid-operation, abort the division without emitting DONE.

Structure
REQ-030 SHALL place the FSM state type (IDLE/RUN/FIN) and the default WIDTH constant in the shared package arith_pkg.
REQ-031 SHALL isolate the WIDTH+1-bit trial subtractor in one sub-module, div_trial_sub, which is purely combinational and built from the team's 1-bit add/sub cell with MODE tied to subtract.

Verification
REQ-032 SHALL cover: START, X=13, Y=3 -> DONE 5 cycles later; Q=4, R=1, DIVZ=0.
REQ-033 SHALL cover: X=15, Y=1 -> Q=15, R=0; X=3, Y=9 -> Q=0, R=3; both at latency 5.
REQ-034 SHALL cover: X=7, Y=0 -> DONE 1 cycle later; Q=15, R=7, DIVZ=1; a following 8/2 gives DIVZ=0, Q=4, R=0.
REQ-035 SHALL cover: START held high with new X/Y throughout a 9/2 run -> single DONE with Q=4, R=1; next operation accepted only from IDLE.
REQ-036 SHALL cover: RST pulsed 2 cycles into a 14/3 run -> no DONE; all outputs 0; a new 14/3 yields Q=4, R=2.
REQ-037 SHALL cover an exhaustive WIDTH=4 sweep over all 256 X/Y pairs, checked against REQ-026 and the Y==0 rule.
